wb_slave_decoder: RTL and testbench

Slave-side end of the i2d SoC Wishbone intercon: takes the single master-side transfer chosen by the intercon arbiter and routes it to one of `WBS_NUM` slaves by address. Returns that slave's read data and ack/err to the master. Registers every outbound and return signal. A per-transfer watchdog converts unmapped addresses and silent slaves into a bus error, so a granted master can never hang the bus.

---
 rtl/wb_slave_decoder.sv | 168 ++++++++++++++++
 tb/tb_wb_slave_decoder.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_slave_decoder.sv
// Slave-side Wishbone decoder: routes the granted master transfer to one slave by
// address, registers all outbound/return signals, and turns silence into a bus error.
module wb_slave_decoder #(
  parameter int WBS_NUM = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   m_cyc_i,
  input  logic                   m_stb_i,
  input  logic                   m_we_i,
  input  logic [31:0]            m_adr_i,
  input  logic [31:0]            m_dat_i,
  input  logic [3:0]             m_sel_i,
  output logic [31:0]            m_dat_o,
  output logic                   m_ack_o,
  output logic                   m_err_o,
  output logic [WBS_NUM-1:0]     s_cyc_o,
  output logic [WBS_NUM-1:0]     s_stb_o,
  output logic                   s_we_o,
  output logic [31:0]            s_adr_o,
  output logic [31:0]            s_dat_o,
  output logic [3:0]             s_sel_o,
  input  logic [WBS_NUM-1:0]     s_ack_i,
  input  logic [WBS_NUM-1:0]     s_err_i,
  input  logic [32*WBS_NUM-1:0]  s_dat_i
);

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_WAIT} state_e;

  localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);

  state_e               state_q, state_d;
  logic [7:0]           wdog_q, wdog_d;
  logic [WBS_NUM-1:0]   sel_q, sel_d;
  logic                 we_q, we_d;
  logic [31:0]          adr_q, adr_d;
  logic [31:0]          wdat_q, wdat_d;
  logic [3:0]           bsel_q, bsel_d;
  logic [31:0]          rdat_q, rdat_d;
  logic                 ack_q, ack_d;
  logic                 err_q, err_d;

  logic [3:0]           req_idx;
  logic                 req_valid;
  logic [WBS_NUM-1:0]   req_onehot;
  logic                 slv_ack;
  logic                 slv_err;
  logic [31:0]          slv_dat;

  assign req_idx   = m_adr_i[31:28];
  assign req_valid = {28'd0, req_idx} < 32'(WBS_NUM);

  // The latched one-hot select doubles as the response mask, so strays from other slaves vanish here.
  assign slv_ack = |(s_ack_i & sel_q);
  assign slv_err = |(s_err_i & sel_q);

  always_comb begin
    req_onehot = '0;
    slv_dat    = '0;
    for (int k = 0; k < WBS_NUM; k++) begin
      req_onehot[k] = (req_idx == 4'(k));
      slv_dat       = slv_dat | (s_dat_i[32*k +: 32] & {32{sel_q[k]}});
    end
  end

  always_comb begin
    // NOTE: every signal gets a default before the case, so no path leaves one unassigned (no latch).
    state_d = state_q;
    wdog_d  = wdog_q;
    sel_d   = sel_q;
    we_d    = we_q;
    adr_d   = adr_q;
    wdat_d  = wdat_q;
    bsel_d  = bsel_q;
    rdat_d  = rdat_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (m_cyc_i && m_stb_i) begin
          if (req_valid) begin
            sel_d   = req_onehot;
            we_d    = m_we_i;
            adr_d   = m_adr_i;
            wdat_d  = m_dat_i;
            bsel_d  = m_sel_i;
            wdog_d  = 8'd0;
            state_d = ST_BUSY;
          end else begin
            err_d   = 1'b1;
            state_d = ST_WAIT;
          end
        end
      end

      ST_BUSY: begin
        if (!m_cyc_i) begin
          sel_d   = '0;
          state_d = ST_IDLE;
        end else if (slv_err) begin
          err_d   = 1'b1;
          sel_d   = '0;
          state_d = ST_WAIT;
        end else if (slv_ack) begin
          rdat_d  = slv_dat;
          ack_d   = 1'b1;
          sel_d   = '0;
          state_d = ST_WAIT;
        end else if (wdog_q == WDOG_LAST) begin
          err_d   = 1'b1;
          sel_d   = '0;
          state_d = ST_WAIT;
        end else begin
          wdog_d  = wdog_q + 8'd1;
        end
      end

      ST_WAIT: begin
        state_d = ST_IDLE;
      end

      default: begin
        sel_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: non-blocking assignments so every flop samples the pre-edge value of its _d.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      wdog_q  <= 8'd0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      adr_q   <= 32'd0;
      wdat_q  <= 32'd0;
      bsel_q  <= 4'd0;
      rdat_q  <= 32'd0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wdog_q  <= wdog_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      wdat_q  <= wdat_d;
      bsel_q  <= bsel_d;
      rdat_q  <= rdat_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  assign m_dat_o = rdat_q;
  assign m_ack_o = ack_q;
  assign m_err_o = err_q;
  assign s_cyc_o = sel_q;
  assign s_stb_o = sel_q;
  assign s_we_o  = we_q;
  assign s_adr_o = adr_q;
  assign s_dat_o = wdat_q;
  assign s_sel_o = bsel_q;

endmodule

// File: tb/tb_wb_slave_decoder.sv
// Randomized bench for wb_slave_decoder: a transaction-level model predicts every
// output per cycle; a single compare process checks the DUT 1 ns after each edge.
module tb_wb_slave_decoder;

  localparam int NS = 4;
  localparam int TO = 8;

  localparam int EV_ACK   = 0;
  localparam int EV_ERR   = 1;
  localparam int EV_ABORT = 2;
  localparam int EV_RESET = 3;

  logic               clk_i = 1'b0;
  logic               rst_i;
  logic               m_cyc_i, m_stb_i, m_we_i;
  logic [31:0]        m_adr_i, m_dat_i;
  logic [3:0]         m_sel_i;
  logic [31:0]        m_dat_o;
  logic               m_ack_o, m_err_o;
  logic [NS-1:0]      s_cyc_o, s_stb_o;
  logic               s_we_o;
  logic [31:0]        s_adr_o, s_dat_o;
  logic [3:0]         s_sel_o;
  logic [NS-1:0]      s_ack_i, s_err_i;
  logic [32*NS-1:0]   s_dat_i;

  wb_slave_decoder #(.WBS_NUM(NS), .TIMEOUT(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
    .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_dat_i(s_dat_i)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  // Expected outputs for the coming edge, written by the driver at the falling edge.
  logic          chk_en = 1'b0;
  logic [NS-1:0] exp_stb;
  logic          exp_ack, exp_err, exp_we;
  logic [31:0]   exp_dat, exp_adr, exp_wdat;
  logic [3:0]    exp_sel;

  // Values the DUT must hold between transfers.
  logic          h_we;
  logic [31:0]   h_adr, h_wdat, h_mdat;
  logic [3:0]    h_sel;

  int cnt_ack, cnt_err, cnt_stb;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk_i);
      #1;
      if (chk_en) begin
        check("s_cyc_o", 32'(s_cyc_o), 32'(exp_stb));
        check("s_stb_o", 32'(s_stb_o), 32'(exp_stb));
        check("m_ack_o", 32'(m_ack_o), 32'(exp_ack));
        check("m_err_o", 32'(m_err_o), 32'(exp_err));
        check("m_dat_o", m_dat_o, exp_dat);
        check("s_we_o",  32'(s_we_o), 32'(exp_we));
        check("s_adr_o", s_adr_o, exp_adr);
        check("s_dat_o", s_dat_o, exp_wdat);
        check("s_sel_o", 32'(s_sel_o), 32'(exp_sel));
        cnt_ack += int'(m_ack_o);
        cnt_err += int'(m_err_o);
        cnt_stb += int'(s_stb_o != '0);
      end
    end
  end

  task automatic publish_held();
    exp_we   = h_we;
    exp_adr  = h_adr;
    exp_wdat = h_wdat;
    exp_sel  = h_sel;
    exp_dat  = h_mdat;
  endtask

  task automatic clear_held();
    h_we = 1'b0; h_adr = '0; h_wdat = '0; h_sel = '0; h_mdat = '0;
  endtask

  task automatic clr_counts();
    cnt_ack = 0; cnt_err = 0; cnt_stb = 0;
  endtask

  task automatic rand_slave_data();
    for (int k = 0; k < NS; k++) s_dat_i[32*k +: 32] = $urandom;
  endtask

  // Idle cycles: never a complete request, random noise everywhere else.
  task automatic idle(input int n);
    for (int t = 0; t < n; t++) begin
      int mode;
      mode    = $urandom_range(0, 2);
      rst_i   = 1'b0;
      m_cyc_i = (mode == 1);
      m_stb_i = (mode == 2);
      m_we_i  = 1'($urandom);
      m_adr_i = $urandom;
      m_dat_i = $urandom;
      m_sel_i = 4'($urandom);
      s_ack_i = NS'($urandom);
      s_err_i = NS'($urandom);
      rand_slave_data();
      exp_stb = '0; exp_ack = 1'b0; exp_err = 1'b0;
      publish_held();
      @(negedge clk_i);
    end
  endtask

  // One master transfer. r: 1-based slave-cycle of the selected slave's response (0 = never);
  // kind: 0 ack, 1 err, 2 both; a: slave-cycle in which the master drops cyc (0 = never);
  // rst_at: slave-cycle in which reset is asserted (0 = never). Called at a falling edge.
  task automatic txn(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                     input logic [3:0] sel, input int r, input int kind, input int a,
                     input int rst_at, input logic [31:0] rdat);
    int            idx, len, ev, last;
    bit            valid;
    logic [NS-1:0] onehot;
    idx    = int'(adr[31:28]);
    valid  = idx < NS;
    onehot = '0;
    if (valid) onehot[idx] = 1'b1;

    if (!valid) begin
      len = 0; ev = EV_ERR;
    end else begin
      len = TO; ev = EV_ERR;
      if (r > 0 && r <= len) begin len = r; ev = (kind == 0) ? EV_ACK : EV_ERR; end
      if (a > 0 && a <= len) begin len = a; ev = EV_ABORT; end
      if (rst_at > 0 && rst_at <= len) begin len = rst_at; ev = EV_RESET; end
    end
    last = (ev == EV_ACK || ev == EV_ERR) ? len + 1 : len;

    for (int t = 0; t <= last; t++) begin
      rst_i   = (ev == EV_RESET && t == len);
      m_cyc_i = !(ev == EV_ABORT && t >= len);
      m_stb_i = m_cyc_i;
      m_we_i  = we;
      m_adr_i = adr;
      m_dat_i = wdat;
      m_sel_i = sel;
      rand_slave_data();
      s_ack_i = NS'($urandom) & NS'($urandom) & ~onehot;
      s_err_i = NS'($urandom) & NS'($urandom) & NS'($urandom) & ~onehot;
      if (t == r && r > 0) begin
        if (kind != 1) s_ack_i = s_ack_i | onehot;
        if (kind != 0) s_err_i = s_err_i | onehot;
      end
      if (valid && ev == EV_ACK && t == len) s_dat_i[32*idx +: 32] = rdat;

      if (ev == EV_RESET && t == len) clear_held();
      else if (valid && t == 0) begin
        h_we = we; h_adr = adr; h_wdat = wdat; h_sel = sel;
      end
      if (ev == EV_ACK && t == len) h_mdat = rdat;

      exp_stb = (t < len) ? onehot : '0;
      exp_ack = (ev == EV_ACK && t == len);
      exp_err = (ev == EV_ERR && t == len);
      publish_held();
      @(negedge clk_i);
    end
    rst_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1;
    m_cyc_i = 1'b0; m_stb_i = 1'b0; m_we_i = 1'b0;
    m_adr_i = '0; m_dat_i = '0; m_sel_i = '0;
    s_ack_i = '0; s_err_i = '0; s_dat_i = '0;
    clear_held();
    exp_stb = '0; exp_ack = 1'b0; exp_err = 1'b0;
    publish_held();
    clr_counts();
    @(negedge clk_i);
    chk_en = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    idle(2);

    // Zero-wait read from slave 1.
    clr_counts();
    txn(1'b0, 32'h1000_0010, 32'h0, 4'hF, 1, 0, 0, 0, 32'hDEAD_BEEF);
    check("zw_stb_cycles", 32'(cnt_stb), 32'd1);
    check("zw_ack_count",  32'(cnt_ack), 32'd1);
    check("zw_err_count",  32'(cnt_err), 32'd0);
    check("zw_rdata",      m_dat_o, 32'hDEAD_BEEF);
    idle(1);

    // Write with wait states to slave 3.
    clr_counts();
    txn(1'b1, 32'h3000_0000, 32'hA5A5_A5A5, 4'b0011, 5, 0, 0, 0, 32'h1234_5678);
    check("wr_stb_cycles", 32'(cnt_stb), 32'd5);
    check("wr_ack_count",  32'(cnt_ack), 32'd1);
    check("wr_adr",        s_adr_o, 32'h3000_0000);
    check("wr_dat",        s_dat_o, 32'hA5A5_A5A5);
    check("wr_sel",        32'(s_sel_o), 32'h3);
    check("wr_we",         32'(s_we_o), 32'h1);

    // Unmapped address.
    clr_counts();
    txn(1'b0, 32'h5000_0000, 32'h0, 4'hF, 0, 0, 0, 0, 32'h0);
    check("unm_stb_cycles", 32'(cnt_stb), 32'd0);
    check("unm_err_count",  32'(cnt_err), 32'd1);
    check("unm_ack_count",  32'(cnt_ack), 32'd0);

    // Silent slave 2 runs into the watchdog.
    clr_counts();
    txn(1'b0, 32'h2000_0040, 32'h0, 4'hF, 0, 0, 0, 0, 32'h0);
    check("to_stb_cycles", 32'(cnt_stb), 32'd8);
    check("to_err_count",  32'(cnt_err), 32'd1);
    check("to_ack_count",  32'(cnt_ack), 32'd0);

    // Master abort in the 3rd slave cycle.
    clr_counts();
    txn(1'b0, 32'h0000_0100, 32'h0, 4'hF, 0, 0, 3, 0, 32'h0);
    check("ab_stb_cycles", 32'(cnt_stb), 32'd3);
    check("ab_ack_count",  32'(cnt_ack), 32'd0);
    check("ab_err_count",  32'(cnt_err), 32'd0);
    idle(1);

    // Ack and err in the same cycle.
    clr_counts();
    txn(1'b0, 32'h1000_0000, 32'h0, 4'hF, 2, 2, 0, 0, 32'h0);
    check("both_err_count", 32'(cnt_err), 32'd1);
    check("both_ack_count", 32'(cnt_ack), 32'd0);

    // Reset while a transfer is in flight.
    clr_counts();
    txn(1'b1, 32'h3000_0008, 32'h0F0F_0F0F, 4'hF, 0, 0, 0, 2, 32'h0);
    check("rst_mdat", m_dat_o, 32'h0);
    check("rst_adr",  s_adr_o, 32'h0);
    check("rst_resp", 32'(cnt_ack + cnt_err), 32'd0);
    idle(1);

    // Strobe held through WAIT, immediately followed by another request.
    clr_counts();
    txn(1'b0, 32'h0000_0004, 32'h0, 4'hF, 1, 0, 0, 0, 32'hCAFE_F00D);
    txn(1'b0, 32'h2000_0004, 32'h0, 4'hF, 1, 0, 0, 0, 32'h0BAD_CAFE);
    check("b2b_stb_cycles", 32'(cnt_stb), 32'd2);
    check("b2b_ack_count",  32'(cnt_ack), 32'd2);

    for (int i = 0; i < 200; i++) begin
      logic [3:0]  ridx;
      int          r, kind, a, rst_at;
      ridx   = 4'($urandom_range(0, 5));
      r      = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 10);
      kind   = $urandom_range(0, 5);
      kind   = (kind < 4) ? 0 : kind - 3;
      a      = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 6) : 0;
      rst_at = ($urandom_range(0, 39) == 0) ? $urandom_range(1, 4) : 0;
      txn(1'($urandom), {ridx, 28'($urandom)}, $urandom, 4'($urandom),
          r, kind, a, rst_at, $urandom);
      idle($urandom_range(0, 2));
    end

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
